// File: rtl/gate_check_pkg.sv
// Shared types, sizes and golden model for the gate response checker.
package gate_check_pkg;

  localparam int unsigned VEC_W       = 4;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned RESP_W      = 3;
  localparam int unsigned NUM_VECTORS = 16;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  // Expected {e,f,g} for vector {a,b,c,d}: e=a&b, f=c&d, g=a&b&c&d.
  function automatic logic [RESP_W-1:0] golden_resp(input logic [VEC_W-1:0] vec);
    return {vec[3] & vec[2], vec[1] & vec[0], &vec};
  endfunction

endpackage

// File: rtl/gate_response_checker_settle_timer.sv
// Down-counter that times the SETTLE window; expires on its last cycle.
module settle_timer
  import gate_check_pkg::*;
#(
  parameter int unsigned LOAD_VALUE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire_c
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= CNT_W'(LOAD_VALUE);
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign expire_c = en && (count_q == CNT_W'(1));

endmodule

// File: rtl/gate_response_checker.sv
// Sweeps all 16 input vectors through a gate under test and scores its responses.
module gate_response_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned SAT_MAX       = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic             e,
  input  logic             f,
  input  logic             g,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [VEC_W-1:0] first_fail_vec
);

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

  state_t           state, state_nx;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [VEC_W-1:0] ff_q, ff_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             expire_c;
  logic             mismatch_c;

  settle_timer #(.LOAD_VALUE(SETTLE_CYCLES)) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == APPLY),
    .en       (state == SETTLE),
    .expire_c (expire_c)
  );

  assign mismatch_c = ({e, f, g} != golden_resp(vec_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = APPLY;
      APPLY:   state_nx = SETTLE;
      SETTLE:  if (expire_c) state_nx = CHECK;
      CHECK:   state_nx = (vec_q == LAST_VEC) ? DONE : APPLY;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs; pass is judged on the post-CHECK count.
  always_comb begin
    vec_d  = vec_q;
    err_d  = err_q;
    ff_d   = ff_q;
    busy_d = busy_q;
    done_d = 1'b0;
    pass_d = pass_q;
    case (state)
      IDLE: begin
        if (start) begin
          vec_d  = '0;
          err_d  = '0;
          ff_d   = '0;
          pass_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      CHECK: begin
        if (mismatch_c) begin
          if (err_q == '0) ff_d = vec_q;
          if (err_q < CNT_W'(SAT_MAX)) err_d = err_q + CNT_W'(1);
        end
        if (vec_q == LAST_VEC) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_d == '0);
        end else begin
          vec_d = vec_q + VEC_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q  <= '0;
      err_q  <= '0;
      ff_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      vec_q  <= vec_d;
      err_q  <= err_d;
      ff_q   <= ff_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end

  assign {a, b, c, d}   = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ff_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker at default parameters.
module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       a, b, c, d, e, f, g;
  logic       busy, done, pass;
  logic [3:0] err_count, first_fail_vec;
  int         checks   = 0;
  int         failures = 0;
  int         mode     = 0;  // 0 good gate, 1 g stuck at 0, 2 f inverted

  always #5 clk = ~clk;

  assign e = a & b;
  assign f = (c & d) ^ (mode == 2);
  assign g = (mode == 1) ? 1'b0 : (a & b & c & d);

  gate_response_checker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .a              (a),
    .b              (b),
    .c              (c),
    .d              (d),
    .e              (e),
    .f              (f),
    .g              (g),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_fail_vec (first_fail_vec)
  );

  task automatic test_reset();
    logic [14:0] outs;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    outs = {a, b, c, d, busy, done, pass, err_count, first_fail_vec};
    checks++;
    if (outs !== 15'h0) begin
      failures++;
      $display("FAIL reset_values: got %h expected %h", outs, 15'h0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    outs = {a, b, c, d, busy, done, pass, err_count, first_fail_vec};
    checks++;
    if (outs !== 15'h0) begin
      failures++;
      $display("FAIL idle_after_reset: got %h expected %h", outs, 15'h0);
    end
  endtask

  // One full pass; cycle 1 is the cycle after the edge that accepts start.
  task automatic run_pass(input string name, input bit repulse, input bit exp_pass,
                          input logic [3:0] exp_err, input logic [3:0] exp_ff);
    int done_cyc = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int vec_err  = 0;
    logic [3:0] vec_exp;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 70; cyc++) begin
      @(negedge clk);
      start = (repulse && (cyc == 10 || cyc == 40)) ? 1'b1 : 1'b0;
      if (cyc == 1) begin
        checks++;
        if ({busy, pass, err_count, first_fail_vec} !== {1'b1, 1'b0, 4'h0, 4'h0}) begin
          failures++;
          $display("FAIL %s start_clear: got busy=%b pass=%b err=%h ff=%h expected 1 0 0 0",
                   name, busy, pass, err_count, first_fail_vec);
        end
      end
      if (cyc <= 64) begin
        vec_exp = 4'((cyc - 1) / 4);
        if ({a, b, c, d} !== vec_exp) vec_err++;
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (cyc == 65) begin
        checks++;
        if ({pass, err_count, first_fail_vec} !== {exp_pass, exp_err, exp_ff}) begin
          failures++;
          $display("FAIL %s result: got pass=%b err=%h ff=%h expected pass=%b err=%h ff=%h",
                   name, pass, err_count, first_fail_vec, exp_pass, exp_err, exp_ff);
        end
      end
    end
    checks++;
    if (vec_err != 0) begin
      failures++;
      $display("FAIL %s vector_stability: got %0d bad cycles expected 0", name, vec_err);
    end
    checks++;
    if (busy_cnt != 64) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d expected 64", name, busy_cnt);
    end
    checks++;
    if (done_cyc != 65) begin
      failures++;
      $display("FAIL %s done_cycle: got %0d expected 65", name, done_cyc);
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
    end
    checks++;
    if ({a, b, c, d, pass, err_count, first_fail_vec} !== {4'hF, exp_pass, exp_err, exp_ff}) begin
      failures++;
      $display("FAIL %s idle_hold: got vec=%h pass=%b err=%h ff=%h expected vec=f pass=%b err=%h ff=%h",
               name, {a, b, c, d}, pass, err_count, first_fail_vec, exp_pass, exp_err, exp_ff);
    end
  endtask

  task automatic test_good();
    mode = 0;
    run_pass("good_gate", 1'b0, 1'b1, 4'h0, 4'h0);
  endtask

  task automatic test_start_ignored();
    mode = 0;
    run_pass("start_repulse", 1'b1, 1'b1, 4'h0, 4'h0);
  endtask

  task automatic test_g_stuck();
    mode = 1;
    run_pass("g_stuck0", 1'b0, 1'b0, 4'h1, 4'hF);
  endtask

  task automatic test_f_inverted();
    mode = 2;
    run_pass("f_inverted", 1'b0, 1'b0, 4'hF, 4'h0);
  endtask

  task automatic test_reset_mid();
    int          done_cnt = 0;
    int          bad_cnt  = 0;
    logic [14:0] outs;
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 30; cyc++) begin
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    checks++;
    if (err_count !== 4'h7) begin
      failures++;
      $display("FAIL mid_pass_errors: got %h expected 7", err_count);
    end
    rst_n = 1'b0;
    #1;
    outs = {a, b, c, d, busy, done, pass, err_count, first_fail_vec};
    checks++;
    if (outs !== 15'h0) begin
      failures++;
      $display("FAIL mid_reset_values: got %h expected %h", outs, 15'h0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      outs = {a, b, c, d, busy, done, pass, err_count, first_fail_vec};
      if (outs !== 15'h0) bad_cnt++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    checks++;
    if (bad_cnt != 0) begin
      failures++;
      $display("FAIL reset_hold: got %0d nonzero cycles expected 0", bad_cnt);
    end
    checks++;
    if (done_cnt != 0) begin
      failures++;
      $display("FAIL aborted_done: got %0d pulses expected 0", done_cnt);
    end
    mode = 0;
    run_pass("after_reset", 1'b0, 1'b1, 4'h0, 4'h0);
  endtask

  initial begin
    test_reset();
    test_good();
    test_start_ignored();
    test_g_stuck();
    test_f_inverted();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_response_checker.md
GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, sets the wait cycles between applying a vector and sampling the response; legal range 1..15.
REQ-002 Parameter SAT_MAX, default 15, is the error-counter saturation value.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 start  input  1  one-cycle request to run a full check pass.
REQ-006 a, b, c, d  output  1 each  stimulus to the gate under test; {a,b,c,d} = vector index, a is MSB.
REQ-007 e, f, g  input  1 each  gate-under-test responses.
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 done  output  1  one-cycle pulse at the end of a pass.
REQ-010 pass  output  1  high when the last completed pass had zero mismatches; held until the next accepted start.
REQ-011 err_count  output  4  mismatching vectors in the current or last pass, saturating at SAT_MAX.
REQ-012 first_fail_vec  output  4  index of the first mismatching vector; 4'h0 when none.

Function
REQ-013 Golden response SHALL be: e = a&b, f = c&d, g = a&b&c&d.
REQ-014 FSM states SHALL be IDLE, APPLY, SETTLE, CHECK and DONE.
REQ-015 IDLE -> APPLY on start=1; start SHALL be ignored in every other state.
REQ-016 An accepted start SHALL clear err_count, first_fail_vec, pass and the vector index to 0.
REQ-017 APPLY SHALL drive the current vector for 1 cycle, then move to SETTLE.
REQ-018 SETTLE SHALL hold the vector for exactly SETTLE_CYCLES cycles, then move to CHECK.
REQ-019 CHECK SHALL compare {e,f,g} against golden for the held vector; any bit mismatch counts as one error.
REQ-020 On the first mismatch of a pass, first_fail_vec SHALL capture the vector index; later mismatches SHALL NOT change it.
REQ-021 err_count SHALL increment per mismatching vector and hold at SAT_MAX, with no wrap.
REQ-022 CHECK -> APPLY with index+1 when index < 15; CHECK -> DONE when index = 15, with no index wrap.
REQ-023 DONE SHALL assert done for 1 cycle, set pass = (err_count == 0), then return to IDLE.
REQ-024 Vectors SHALL remain stable from APPLY through CHECK, so each vector occupies SETTLE_CYCLES+2 cycles.
REQ-025 A pass SHALL take 16*(SETTLE_CYCLES+2)+1 cycles from start acceptance to the done pulse; this is 65 cycles at default.
REQ-026 In IDLE, a..d SHALL hold the last applied vector.

Reset
REQ-027 rst_n=0 SHALL immediately force state to IDLE and set a..d=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0 and vector index 0.
REQ-028 Reset mid-pass SHALL abandon the pass; no done pulse is produced, and the next start SHALL run all 16 vectors.
REQ-029 Deassertion SHALL be treated as synchronous to clk; the first start is accepted at or after the first rising edge with rst_n=1.

Structure
REQ-030 Shared package gate_check_pkg SHALL hold the FSM state enum, NUM_VECTORS=16, and the golden-response function.
REQ-031 One sub-module, settle_timer, SHALL implement the SETTLE down-counter (load, count, expire pulse); everything else stays in gate_response_checker.

Verification (default parameters)
REQ-032 Correct gate model, start pulse -> busy for 64 cycles, done at cycle 65, pass=1, err_count=0, first_fail_vec=0.
REQ-033 g stuck at 0 -> err_count=1, first_fail_vec=4'hF, pass=0.
REQ-034 f inverted -> all 16 vectors mismatch, err_count=15 (saturated), first_fail_vec=4'h0, pass=0.
REQ-035 start re-pulsed at cycles 10 and 40 of a pass -> ignored, done still at cycle 65, exactly one done pulse.
REQ-036 rst_n low at cycle 30 then a new start -> all outputs at reset values during reset, no done pulse from the aborted pass, fresh pass runs vectors 0..15 with correct results.
REQ-037 Bench SHALL check that a..d never change between APPLY and CHECK of one vector.
